// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, sticky error flags and a
// first-word-fall-through receive FIFO.
module uart_rx_fifo #(
   parameter int unsigned CLK_PER_BIT = 5206,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                          sysclk,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          rx_busy,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overflow,
   input  logic                          err_clr
);

   localparam int unsigned HALF = CLK_PER_BIT / 2;
   localparam int unsigned TW   = $clog2(CLK_PER_BIT);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               state_q;
   logic                 rx_meta_q, rx_s_q;
   logic [TW-1:0]        tmr_q;
   logic [2:0]           bit_q;
   logic                 stop_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bad_q;
   logic                 push_q;
   logic [DATA_BITS-1:0] push_data_q;
   logic                 busy_q;
   logic                 frame_err_q, parity_err_q, overflow_q;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [AW:0]          count_q;

   logic sample, par_exp, last_stop, fe_set, pe_set, ovf_set, pop, wr;

   // The start bit is sampled after HALF cycles, every later bit one full period on.
   always_comb begin
      sample    = (state_q == S_START) ? (tmr_q == TW'(HALF - 1))
                                       : (tmr_q == TW'(CLK_PER_BIT - 1));
      par_exp   = (PARITY == 1) ? ~^shift_q : ^shift_q;
      last_stop = (stop_q == 1'(STOP_BITS - 1));
      fe_set    = (state_q == S_STOP) && sample && !rx_s_q;
      pe_set    = (state_q == S_STOP) && sample && rx_s_q && last_stop && par_bad_q;
      pop       = rd_en && !empty;
      wr        = push_q && (!full || pop);
      ovf_set   = push_q && full && !pop;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         bit_q       <= '0;
         stop_q      <= 1'b0;
         shift_q     <= '0;
         par_bad_q   <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         push_q    <= 1'b0;
         tmr_q     <= sample ? '0 : tmr_q + TW'(1);
         case (state_q)
            S_IDLE: if (!rx_s_q) begin
               state_q   <= S_START;
               tmr_q     <= '0;
               bit_q     <= '0;
               stop_q    <= 1'b0;
               par_bad_q <= 1'b0;
               busy_q    <= 1'b1;
            end
            S_START: if (sample) begin
               if (rx_s_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: if (sample) begin
               shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (bit_q == 3'(DATA_BITS - 1)) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
               else                            bit_q   <= bit_q + 3'd1;
            end
            S_PARITY: if (sample) begin
               par_bad_q <= (rx_s_q != par_exp);
               state_q   <= S_STOP;
            end
            S_STOP: if (sample) begin
               if (!rx_s_q) begin
                  state_q <= S_WAIT_HIGH;
               end else if (last_stop) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  push_q      <= !par_bad_q;
                  push_data_q <= shift_q;
               end else begin
                  stop_q <= 1'b1;
               end
            end
            S_WAIT_HIGH: if (rx_s_q) begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // A flag-setting event overrides a simultaneous clear.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         frame_err_q  <= fe_set  | (frame_err_q  & ~err_clr);
         parity_err_q <= pe_set  | (parity_err_q & ~err_clr);
         overflow_q   <= ovf_set | (overflow_q   & ~err_clr);
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr, pop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (wr) mem[wr_ptr_q] <= push_data_q;
   end

   assign empty      = (count_q == '0);
   assign full       = (count_q == (AW + 1)'(FIFO_DEPTH));
   assign count      = count_q;
   assign rd_data    = empty ? '0 : mem[rd_ptr_q];
   assign rx_busy    = busy_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances (8N1, even parity, depth 4)
// with a per-instance scoreboard of expected FIFO contents.
module tb_uart_rx_fifo;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       rxv, rdenv, clrv;
   logic [2:0][7:0]  rdv;
   logic [2:0][3:0]  cntv;
   logic [2:0]       emp, ful, bsy, fe, pe, ov;
   logic [2:0]       cnt2;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb0[$];
   logic [7:0] sb1[$];
   logic [7:0] sb2[$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) d0 (
      .sysclk(clk), .reset(reset), .rx(rxv[0]), .rd_en(rdenv[0]), .rd_data(rdv[0]),
      .empty(emp[0]), .full(ful[0]), .count(cntv[0]), .rx_busy(bsy[0]), .frame_err(fe[0]),
      .parity_err(pe[0]), .overflow(ov[0]), .err_clr(clrv[0]));

   uart_rx_fifo #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) d1 (
      .sysclk(clk), .reset(reset), .rx(rxv[1]), .rd_en(rdenv[1]), .rd_data(rdv[1]),
      .empty(emp[1]), .full(ful[1]), .count(cntv[1]), .rx_busy(bsy[1]), .frame_err(fe[1]),
      .parity_err(pe[1]), .overflow(ov[1]), .err_clr(clrv[1]));

   uart_rx_fifo #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
      .sysclk(clk), .reset(reset), .rx(rxv[2]), .rd_en(rdenv[2]), .rd_data(rdv[2]),
      .empty(emp[2]), .full(ful[2]), .count(cnt2), .rx_busy(bsy[2]), .frame_err(fe[2]),
      .parity_err(pe[2]), .overflow(ov[2]), .err_clr(clrv[2]));

   assign cntv[2] = {1'b0, cnt2};

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sb_push(int s, logic [7:0] d);
      case (s)
         0:       sb0.push_back(d);
         1:       sb1.push_back(d);
         default: sb2.push_back(d);
      endcase
   endtask

   function automatic logic [7:0] sb_pop(int s);
      logic [7:0] v;
      v = 8'hxx;
      case (s)
         0:       if (sb0.size() > 0) v = sb0.pop_front();
         1:       if (sb1.size() > 0) v = sb1.pop_front();
         default: if (sb2.size() > 0) v = sb2.pop_front();
      endcase
      return v;
   endfunction

   // One frame at 16 clocks/bit. The last stop sample lands 11 edges into the
   // stop bit and the push one edge later; chk verifies that edge exactly.
   task automatic send(int s, logic [7:0] d, int par, bit bad_par, int stop_low,
                       bit pop_at_push, bit chk);
      logic       p;
      logic [3:0] c0;
      rxv[s] = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rxv[s] = d[i];
         tick(16);
      end
      if (par != 0) begin
         p = (par == 1) ? ~^d : ^d;
         if (bad_par) p = ~p;
         rxv[s] = p;
         tick(16);
      end
      if (stop_low > 0) begin
         rxv[s] = 1'b0;
         tick(16 * stop_low);
         check("wait_high_busy", bsy[s], 1);
         check("frame_err_set", fe[s], 1);
         rxv[s] = 1'b1;
         tick(16);
      end else begin
         rxv[s] = 1'b1;
         tick(10);
         c0 = cntv[s];
         if (chk) check("busy_before_last_sample", bsy[s], 1);
         tick(1);
         if (chk) begin
            check("busy_after_last_sample", bsy[s], 0);
            check("count_at_sample_edge", cntv[s], c0);
         end
         if (pop_at_push) begin
            check("head_at_pop", rdv[s], sb_pop(s));
            rdenv[s] = 1'b1;
         end
         tick(1);
         rdenv[s] = 1'b0;
         if (chk) check("count_after_push", cntv[s], pop_at_push ? c0 : c0 + 4'd1);
         tick(4);
      end
   endtask

   task automatic read_check(int s);
      check("rd_data", rdv[s], sb_pop(s));
      rdenv[s] = 1'b1;
      tick(1);
      rdenv[s] = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      rxv   = '1;
      rdenv = '0;
      clrv  = '0;
      tick(3);
      check("rst_empty", emp[0], 1);
      check("rst_full", ful[0], 0);
      check("rst_count", cntv[0], 0);
      check("rst_busy", bsy[0], 0);
      check("rst_flags", {fe[0], pe[0], ov[0]}, 0);
      check("rst_rd_data", rdv[0], 0);
      reset = 1'b0;
      tick(2);

      // 8N1 back-to-back frames with exact push-latency check
      send(0, 8'h38, 0, 0, 0, 0, 1);
      sb_push(0, 8'h38);
      check("count_one", cntv[0], 1);
      send(0, 8'h49, 0, 0, 0, 0, 0);
      sb_push(0, 8'h49);
      check("count_two", cntv[0], 2);
      read_check(0);
      read_check(0);
      check("drained_empty", emp[0], 1);
      check("drained_rd_data", rdv[0], 0);

      // false start: 5 low cycles
      rxv[0] = 1'b0;
      tick(5);
      check("false_start_busy", bsy[0], 1);
      rxv[0] = 1'b1;
      tick(10);
      check("false_start_idle", bsy[0], 0);
      check("false_start_empty", emp[0], 1);
      check("false_start_flags", {fe[0], pe[0], ov[0]}, 0);

      // even parity: good frame kept, bad frame dropped
      send(1, 8'h55, 2, 0, 0, 0, 0);
      sb_push(1, 8'h55);
      send(1, 8'h55, 2, 1, 0, 0, 0);
      check("parity_count", cntv[1], 1);
      check("parity_err_set", pe[1], 1);
      check("parity_no_frame_err", fe[1], 0);
      read_check(1);
      check("parity_empty", emp[1], 1);
      clrv[1] = 1'b1;
      tick(1);
      clrv[1] = 1'b0;
      check("parity_err_clr", pe[1], 0);

      // stop bit held low for 3 periods, then a clean frame
      send(0, 8'hA5, 0, 0, 3, 0, 0);
      check("frame_err_sticky", fe[0], 1);
      check("frame_dropped", cntv[0], 0);
      send(0, 8'h12, 0, 0, 0, 0, 0);
      sb_push(0, 8'h12);
      check("after_ferr_count", cntv[0], 1);
      read_check(0);

      // depth 4: fifth frame overflows
      for (int i = 1; i <= 5; i++) begin
         send(2, 8'(i), 0, 0, 0, 0, 0);
         if (i <= 4) sb_push(2, 8'(i));
      end
      check("ovf_full", ful[2], 1);
      check("ovf_count", cntv[2], 4);
      check("ovf_flag", ov[2], 1);
      for (int i = 0; i < 4; i++) read_check(2);
      check("ovf_drained", emp[2], 1);
      clrv[2] = 1'b1;
      tick(1);
      clrv[2] = 1'b0;
      check("ovf_clr", ov[2], 0);

      // depth 4 again, pop coincides with the fifth push
      for (int i = 1; i <= 4; i++) begin
         send(2, 8'(i), 0, 0, 0, 0, 0);
         sb_push(2, 8'(i));
      end
      send(2, 8'h05, 0, 0, 0, 1, 1);
      sb_push(2, 8'h05);
      check("pop_push_count", cntv[2], 4);
      check("pop_push_full", ful[2], 1);
      check("pop_push_no_ovf", ov[2], 0);
      for (int i = 0; i < 4; i++) read_check(2);
      check("pop_push_drained", emp[2], 1);

      // reset in the middle of the data bits
      send(0, 8'h33, 0, 0, 0, 0, 0);
      rxv[0] = 1'b0;
      tick(56);
      check("pre_reset_busy", bsy[0], 1);
      reset = 1'b1;
      tick(1);
      check("midrst_empty", emp[0], 1);
      check("midrst_count", cntv[0], 0);
      check("midrst_busy", bsy[0], 0);
      check("midrst_flags", {fe[0], pe[0], ov[0]}, 0);
      check("midrst_rd_data", rdv[0], 0);
      sb0.delete();
      reset  = 1'b0;
      rxv[0] = 1'b1;
      tick(20);
      send(0, 8'h7E, 0, 0, 0, 0, 0);
      sb_push(0, 8'h7E);
      check("post_reset_count", cntv[0], 1);
      read_check(0);
      check("post_reset_empty", emp[0], 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO. It replaces the fixed 8N1 receive path that sits behind the CPU's UART_RX pin in the pipeline SoC. The block adds:
- configurable data width, parity, stop bits and baud divisor;
- false-start rejection;
- sticky framing, parity and overflow error flags;
- a first-word-fall-through FIFO, so the CPU's peripheral read logic can drain bytes without losing back-to-back frames.

## Interface
Parameters:
- CLK_PER_BIT, 5206, sysclk cycles per bit period; must be ≥ 4.
- DATA_BITS, 8, data bits per frame, 5..8, LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 8, number of entries; power of two, ≥ 2.

Ports:
- sysclk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rd_en  input  1  pops the head entry when empty = 0.
- rd_data  output  DATA_BITS  head of FIFO (fall-through); 0 when empty.
- empty  output  1  FIFO holds no entries.
- full  output  1  count == FIFO_DEPTH.
- count  output  $clog2(FIFO_DEPTH)+1  occupancy.
- rx_busy  output  1  receiver FSM not in IDLE.
- frame_err  output  1  sticky: a stop bit was sampled low.
- parity_err  output  1  sticky: parity mismatch.
- overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
- err_clr  input  1  clears all three sticky flags.

## Operation
Synchroniser:
- rx passes through two flops; the FSM uses only the second flop output, rx_s.
- The synchroniser resets to 1.

FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when rx_s = 0, go to START and clear the bit counter. That cycle is t0.
- Sample points: t0 + HALF + k·CLK_PER_BIT, with HALF = CLK_PER_BIT/2 (integer division).
  - k = 0 is the start bit.
  - k = 1..DATA_BITS are the data bits.
  - The parity bit follows, if enabled.
  - Then one or two stop bits.
- START: if rx_s = 1 at the start sample, this is a false start; return to IDLE with no flags set.
- DATA: shift the sample in LSB first.
- PARITY: compare against the computed odd or even parity.
- STOP: every stop bit is sampled. Any low stop sample causes the following:
  - frame_err is set;
  - the frame is discarded;
  - the FSM goes to WAIT_HIGH, which waits for rx_s = 1 before entering IDLE.
- End of frame (last stop sample):
  - A parity-failed frame sets parity_err and is discarded.
  - Otherwise the frame is pushed to the FIFO, or overflow is set if the FIFO is full and no pop happens that cycle.
  - The FSM then enters IDLE.
- err_clr clears the flags. If a flag-setting event lands in the same cycle as err_clr, set wins.

FIFO:
- Circular buffer of FIFO_DEPTH entries with wrapping read and write pointers.
- rd_en while empty is ignored.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds when full, and when empty the push is not popped.

## Timing
- Reset values:
  - empty = 1;
  - full, count, rx_busy, frame_err, parity_err, overflow all 0;
  - rd_data = 0;
  - FSM in IDLE;
  - pointers at 0.
- rx falling before sysclk edge n gives t0 = edge n+2.
- Push latency: empty deasserts, and count increments, on the edge after the last stop sample.
- Pop: rd_data shows the next entry on the edge after an accepted rd_en.
- rx_busy is 1 from t0 through the last stop sample (or the WAIT_HIGH exit). It is 0 the cycle after.
- Reset mid-frame aborts the frame: FIFO empty, flags cleared, next start searched from IDLE.

## Test plan
- 8N1, CLK_PER_BIT = 16: send 0x38 then 0x49.
  - Required: count goes 1 then 2; rd_data = 0x38.
  - After rd_en: rd_data = 0x49; after a second rd_en: empty = 1.
  - Confirm the push-latency edge exactly.
- False start: rx low for 5 cycles then high (CLK_PER_BIT = 16).
  - Required: rx_busy pulses, then returns to IDLE; no push; all flags 0.
- PARITY = 2: send 0x55 with the correct parity bit, then 0x55 with the wrong parity bit.
  - Required: first byte is pushed; second is dropped; parity_err = 1.
  - err_clr then clears parity_err to 0.
- Stop bit held low for 3 bit periods after 0xA5.
  - Required: frame_err = 1, nothing pushed, FSM waits in WAIT_HIGH.
  - The next valid 0x12 is received correctly.
- FIFO_DEPTH = 4: send 5 frames 0x01..0x05 with no reads.
  - Required: full = 1, count = 4, overflow = 1; FIFO holds 0x01..0x04.
  - Repeat with rd_en asserted on the 5th push cycle: count stays 4, no overflow, and 0x05 is stored.
- Reset asserted during the DATA bits of a frame.
  - Required: all outputs at reset values the next cycle; a subsequent 0x7E is received intact.
